// File: rtl/pooling_average_accum_if.sv
// Stream bundle for the average-pooling engine: IFM beats in, averages out.
// slave = engine side, master = feeder/consumer side.
interface pooling_average_accum_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*DATA_W-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pooling_average_accum.sv
// Global average pooling: per-channel BRAM accumulate, then scaled drain.
// Ports: clk, reset_n, start, cfg_*, stream bundle s (slave), busy, done.
module pooling_average_accum #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int ACC_W  = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_W:0]       cfg_groups,
  input  logic [15:0]           cfg_pixels,
  input  logic [15:0]           cfg_recip,
  input  logic [4:0]            cfg_shift,
  pooling_average_accum_if.slave s,
  output logic                  busy,
  output logic                  done
);
  localparam int W    = LANES*DATA_W;
  localparam int AW   = LANES*ACC_W;
  localparam int PW   = ACC_W + 17;
  localparam int MAXV = 2**DATA_W - 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, FIN} state_t;
  state_t st, st_nx;

  logic [ADDR_W:0]   groups;
  logic [15:0]       pixels;
  logic [15:0]       recip;
  logic [4:0]        shift;
  logic [ADDR_W:0]   g;
  logic [15:0]       p;
  logic              acc_done;
  logic              wr_vld;
  logic              wr_init;
  logic              wr_last;
  logic              fwd;
  logic [ADDR_W-1:0] wr_addr;
  logic [W-1:0]      wr_lanes;
  logic [AW-1:0]     wr_data;
  logic [AW-1:0]     fwd_data;
  logic [AW-1:0]     rd_q;
  logic [AW-1:0]     mem [DEPTH];
  logic              ren;
  logic [ADDR_W-1:0] raddr;
  logic [ADDR_W:0]   rd_g;
  logic              s1;
  logic              drain_live;
  logic [W-1:0]      fifo [2];
  logic              wp;
  logic              rp;
  logic [1:0]        cnt;
  logic              acc;
  logic              last_beat;
  logic              issue;
  logic              pop;
  logic [2:0]        free;
  logic [W-1:0]      scaled;
  logic [PW-1:0]     prod;

  assign busy = (st != IDLE);
  assign done = (st == FIN);

  assign s.in_ready  = (st == ACCUM) && !acc_done;
  assign s.out_valid = (cnt != 2'd0);
  assign s.out_data  = fifo[rp];

  assign acc       = s.in_valid && s.in_ready;
  assign last_beat = (g == groups - 1'b1) && (p == pixels - 16'd1);
  assign pop       = s.out_valid && s.out_ready;
  // Credit: a read may issue only if its word is sure to find a slot.
  assign free  = 3'd2 - {1'b0, cnt} + {2'b0, pop};
  assign issue = (st == DRAIN) && drain_live && (rd_g != groups)
              && (free > {2'b0, s1});
  assign ren   = acc || issue;
  assign raddr = (st == ACCUM) ? g[ADDR_W-1:0] : rd_g[ADDR_W-1:0];

  // Init pixel adds to zero; a same-address write one cycle ahead is
  // forwarded because the BRAM read saw the pre-write contents.
  always_comb begin
    wr_data = '0;
    for (int k = 0; k < LANES; k++) begin
      wr_data[k*ACC_W +: ACC_W] =
        (wr_init ? '0 :
         fwd ? fwd_data[k*ACC_W +: ACC_W] : rd_q[k*ACC_W +: ACC_W])
        + ACC_W'(wr_lanes[k*DATA_W +: DATA_W]);
    end
  end

  always_comb begin
    scaled = '0;
    prod   = '0;
    for (int k = 0; k < LANES; k++) begin
      prod = PW'(rd_q[k*ACC_W +: ACC_W]) * PW'(recip);
      if (shift != 5'd0)
        prod = prod + (PW'(1) << (shift - 5'd1));
      prod = prod >> shift;
      scaled[k*DATA_W +: DATA_W] =
        (prod > PW'(MAXV)) ? '1 : prod[DATA_W-1:0];
    end
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE:
        if (start)
          st_nx = (cfg_groups == '0 || cfg_pixels == '0) ? FIN : ACCUM;
      ACCUM:
        if (wr_vld && wr_last) st_nx = DRAIN;
      DRAIN:
        if (pop && cnt == 2'd1 && !s1 && rd_g == groups) st_nx = FIN;
      FIN:
        st_nx = IDLE;
      default:
        st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_vld) mem[wr_addr] <= wr_data;
    if (ren) rd_q <= mem[raddr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st         <= IDLE;
      groups     <= '0;
      pixels     <= '0;
      recip      <= '0;
      shift      <= '0;
      g          <= '0;
      p          <= '0;
      acc_done   <= 1'b0;
      wr_vld     <= 1'b0;
      wr_init    <= 1'b0;
      wr_last    <= 1'b0;
      wr_addr    <= '0;
      wr_lanes   <= '0;
      fwd        <= 1'b0;
      fwd_data   <= '0;
      rd_g       <= '0;
      s1         <= 1'b0;
      drain_live <= 1'b0;
      fifo[0]    <= '0;
      fifo[1]    <= '0;
      wp         <= 1'b0;
      rp         <= 1'b0;
      cnt        <= '0;
    end else begin
      st         <= st_nx;
      drain_live <= (st == DRAIN);
      wr_vld     <= acc;
      s1         <= issue;
      if (st == IDLE && start) begin
        groups   <= cfg_groups;
        pixels   <= cfg_pixels;
        recip    <= cfg_recip;
        shift    <= cfg_shift;
        g        <= '0;
        p        <= '0;
        rd_g     <= '0;
        acc_done <= 1'b0;
      end
      if (acc) begin
        wr_addr  <= g[ADDR_W-1:0];
        wr_init  <= (p == 16'd0);
        wr_lanes <= s.in_data;
        wr_last  <= last_beat;
        fwd      <= wr_vld && (wr_addr == g[ADDR_W-1:0]);
        fwd_data <= wr_data;
        if (last_beat) acc_done <= 1'b1;
        if (g == groups - 1'b1) begin
          g <= '0;
          p <= p + 16'd1;
        end else begin
          g <= g + 1'b1;
        end
      end
      if (issue) rd_g <= rd_g + 1'b1;
      if (s1) begin
        fifo[wp] <= scaled;
        wp       <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, s1} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_pooling_average_accum.sv
// Randomised bench for pooling_average_accum against a behavioural model.
// Checks every accepted output word, stall stability, and pinned literals.
module tb_pooling_average_accum;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  cfg_groups = '0;
  logic [15:0] cfg_pixels = '0;
  logic [15:0] cfg_recip = '0;
  logic [4:0]  cfg_shift = '0;
  logic        busy;
  logic        done;

  pooling_average_accum_if #(.DATA_W(8), .LANES(4)) bus ();

  pooling_average_accum dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .cfg_groups(cfg_groups),
    .cfg_pixels(cfg_pixels),
    .cfg_recip(cfg_recip),
    .cfg_shift(cfg_shift),
    .s(bus),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int rdy_pct = 100;
  int done_cnt = 0;
  logic [31:0] beats [$];
  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];
  logic        stall_v = 1'b0;
  logic [31:0] stall_d = '0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = ($urandom_range(99) < rdy_pct);
    end
  end

  always @(negedge clk) if (reset_n && done) done_cnt++;

  always @(negedge clk) begin
    if (!reset_n) begin
      stall_v = 1'b0;
    end else begin
      if (stall_v) begin
        n_cmp++;
        if (!bus.out_valid || bus.out_data !== stall_d) begin
          n_err++;
          $display("FAIL stall_hold: got v=%0b %h required v=1 %h",
                   bus.out_valid, bus.out_data, stall_d);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL extra_word: got %h required none", bus.out_data);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (bus.out_data !== e) begin
            n_err++;
            $display("FAIL out_word: got %h required %h", bus.out_data, e);
          end
          got_q.push_back(bus.out_data);
        end
      end
      stall_v = bus.out_valid && !bus.out_ready;
      stall_d = bus.out_data;
    end
  end

  // Reference: sums per channel mod 2^32, then multiply/round/shift/clip.
  task automatic build_exp(int gr, int px, int rc, int sh);
    longint unsigned sum [];
    sum = new[gr*4];
    foreach (sum[i]) sum[i] = 0;
    for (int pi = 0; pi < px; pi++)
      for (int gi = 0; gi < gr; gi++) begin
        logic [31:0] b;
        b = beats[pi*gr + gi];
        for (int k = 0; k < 4; k++)
          sum[gi*4+k] = (sum[gi*4+k] + longint'(b[k*8 +: 8])) & 64'hFFFF_FFFF;
      end
    for (int gi = 0; gi < gr; gi++) begin
      logic [31:0] w;
      w = '0;
      for (int k = 0; k < 4; k++) begin
        longint unsigned pr;
        pr = sum[gi*4+k] * longint'(rc);
        if (sh > 0) pr = (pr + (64'd1 << (sh-1))) >> sh;
        w[k*8 +: 8] = (pr > 255) ? 8'hFF : pr[7:0];
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic fill_rand(int n);
    beats.delete();
    repeat (n) beats.push_back($urandom);
  endtask

  task automatic start_run(int gr, int px, int rc, int sh);
    @(posedge clk);
    #1;
    start      = 1'b1;
    cfg_groups = 9'(gr);
    cfg_pixels = 16'(px);
    cfg_recip  = 16'(rc);
    cfg_shift  = 5'(sh);
    @(posedge clk);
    #1;
    start      = 1'b0;
    cfg_groups = 9'($urandom);
    cfg_pixels = 16'($urandom);
    cfg_recip  = 16'($urandom);
    cfg_shift  = 5'($urandom);
  endtask

  task automatic feed(int gap_pct, int n);
    for (int i = 0; i < n; i++) begin
      bit ok;
      while ($urandom_range(99) < gap_pct) begin
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = beats[i];
      ok = 1'b0;
      for (int t = 0; t < 300; t++) begin
        @(negedge clk);
        if (bus.in_ready) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        n_cmp++;
        n_err++;
        $display("FAIL in_ready_timeout: got 0 required 1");
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(int budget);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got 0 required 1");
    end
  endtask

  task automatic go(int gr, int px, int rc, int sh, int gap, int rdy,
                    bit poke);
    int d0;
    got_q.delete();
    exp_q.delete();
    build_exp(gr, px, rc, sh);
    rdy_pct = rdy;
    d0 = done_cnt;
    start_run(gr, px, rc, sh);
    if (poke) begin
      fork
        feed(gap, gr*px);
        begin
          repeat (3) @(posedge clk);
          #1;
          start      = 1'b1;
          cfg_groups = 9'd1;
          cfg_pixels = 16'd0;
          @(posedge clk);
          #1;
          start      = 1'b0;
        end
      join
    end else begin
      feed(gap, gr*px);
    end
    wait_done(4000);
    repeat (3) @(negedge clk);
    chk("all_words_out", 64'(exp_q.size()), 64'd0);
    chk("done_pulses", 64'(done_cnt - d0), 64'd1);
    rdy_pct = 100;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    reset_n = 1'b1;

    // single group, back-to-back: forwarding path
    beats.delete();
    repeat (4) beats.push_back(32'h0403_0201);
    go(1, 4, 1, 2, 0, 100, 1'b0);
    chk("t1_count", 64'(got_q.size()), 64'd1);
    chk("t1_word", 64'(got_q[0]), 64'h0403_0201);

    // rounding of halves
    fill_rand(6);
    beats[1] = 32'hFF00_0201;
    beats[4] = 32'h0001_0202;
    go(3, 2, 1, 1, 0, 100, 1'b0);
    chk("t2_count", 64'(got_q.size()), 64'd3);
    chk("t2_group1", 64'(got_q[1]), 64'h8001_0202);

    // 7x7 all-max with reciprocal of 49
    beats.delete();
    repeat (49) beats.push_back(32'hFFFF_FFFF);
    go(1, 49, 1337, 16, 20, 70, 1'b0);
    chk("t3_recip", 64'(got_q[0]), 64'hFFFF_FFFF);
    beats.delete();
    repeat (2) beats.push_back(32'hFFFF_FFFF);
    go(1, 2, 1, 0, 0, 100, 1'b0);
    chk("t3_sat", 64'(got_q[0]), 64'hFFFF_FFFF);

    // gaps and backpressure
    fill_rand(24);
    go(8, 3, $urandom_range(65535), $urandom_range(20), 40, 50, 1'b0);
    chk("t4_count", 64'(got_q.size()), 64'd8);

    // reset during the second pixel, then a clean short run
    fill_rand(9);
    exp_q.delete();
    start_run(3, 3, 1, 0);
    feed(0, 4);
    reset_n = 1'b0;
    #2;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    fill_rand(2);
    go(2, 1, 1, 0, 0, 100, 1'b0);
    chk("t5_word0", 64'(got_q[0]), 64'(beats[0]));
    chk("t5_word1", 64'(got_q[1]), 64'(beats[1]));

    // zero pixels: one busy cycle with done, no output
    begin
      int d0;
      exp_q.delete();
      d0 = done_cnt;
      start_run(2, 0, 1, 0);
      @(negedge clk);
      chk("t6_busy", 64'(busy), 64'd1);
      chk("t6_done", 64'(done), 64'd1);
      @(negedge clk);
      chk("t6_idle_busy", 64'(busy), 64'd0);
      chk("t6_idle_done", 64'(done), 64'd0);
      repeat (3) @(negedge clk);
      chk("t6_done_pulses", 64'(done_cnt - d0), 64'd1);
    end

    // start pulsed mid-run is ignored
    fill_rand(8);
    go(4, 2, $urandom_range(65535), $urandom_range(16), 20, 60, 1'b1);
    chk("t7_count", 64'(got_q.size()), 64'd4);

    for (int r = 0; r < 6; r++) begin
      int gr;
      int px;
      gr = $urandom_range(1, 12);
      px = $urandom_range(1, 5);
      fill_rand(gr*px);
      go(gr, px, $urandom_range(65535), $urandom_range(20),
         $urandom_range(50), $urandom_range(30, 100), 1'b0);
      chk("rand_count", 64'(got_q.size()), 64'(gr));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
